// File: rtl/rs_syndrome_gen.sv
// Reed-Solomon syndrome generator over GF(2^M).
// Symbols enter highest-degree first and are folded into TWO_T parallel
// Horner accumulators. After N symbols the syndromes are streamed out one
// per beat, along with a flag that is set when the word is error-free.
module rs_syndrome_gen #(
   parameter int M         = 4,
   parameter int N         = 15,
   parameter int TWO_T     = 4,
   parameter int PRIM_POLY = 19,
   parameter int FCR       = 1
) (
   input  logic                                   CLK,
   input  logic                                   RESET,
   input  logic                                   CLR,
   input  logic                                   IN_VALID,
   input  logic [M-1:0]                           IN_SYMBOL,
   output logic                                   IN_READY,
   output logic                                   OUT_VALID,
   input  logic                                   OUT_READY,
   output logic [M-1:0]                           OUT_SYNDROME,
   output logic [((TWO_T > 1) ? $clog2(TWO_T) : 1)-1:0] OUT_INDEX,
   output logic                                   OUT_LAST,
   output logic                                   ERR_FREE
);

   localparam int IDX_W = (TWO_T > 1) ? $clog2(TWO_T) : 1;
   localparam int CNT_W = $clog2(N);
   localparam logic [M:0] POLY = PRIM_POLY[M:0];

   // Reject a reduction polynomial without the x^M term, or too many syndromes.
   if (POLY[M] != 1'b1) begin : g_bad_poly
      $error("rs_syndrome_gen: PRIM_POLY must have bit M set");
   end
   if (TWO_T >= N) begin : g_bad_two_t
      $error("rs_syndrome_gen: TWO_T must be less than N");
   end

   // Multiply by x, reducing modulo the primitive polynomial.
   function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
      logic [M-1:0] r;
      r = a << 1;
      if (a[M-1]) r = r ^ POLY[M-1:0];
      return r;
   endfunction

   // General GF(2^M) product; with a constant operand this folds to XOR gates.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] p;
      logic [M-1:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < M; i++) begin
         if (b[i]) p = p ^ aa;
         aa = gf_xtime(aa);
      end
      return p;
   endfunction

   // alpha^e with alpha = x, evaluated at elaboration time for the root constants.
   function automatic logic [M-1:0] gf_pow(input int e);
      logic [M-1:0] r;
      r    = '0;
      r[0] = 1'b1;
      for (int i = 0; i < e; i++) r = gf_xtime(r);
      return r;
   endfunction

   typedef enum logic {ACCUM, DRAIN} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [M-1:0]     syn      [TWO_T];
   logic [M-1:0]     acc_next [TWO_T];
   logic             acc_nonzero;
   logic [IDX_W-1:0] idx_inc;

   // One Horner step per syndrome: the first symbol loads, later ones multiply-accumulate.
   for (genvar j = 0; j < TWO_T; j++) begin : g_root
      localparam logic [M-1:0] ROOT = gf_pow(FCR + j);
      assign acc_next[j] = (count == '0) ? IN_SYMBOL : (gf_mul(syn[j], ROOT) ^ IN_SYMBOL);
   end

   // Zero detect over the values the accumulators take on the final accept.
   always_comb begin
      acc_nonzero = 1'b0;
      for (int j = 0; j < TWO_T; j++) acc_nonzero = acc_nonzero | (|acc_next[j]);
   end

   assign idx_inc = OUT_INDEX + IDX_W'(1);

   // Frame control, accumulators and registered output beats.
   // NOTE: the accumulators are a small register array, not a RAM, so they are
   // reset explicitly; an abort must never leak a stale partial sum.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= ACCUM;
         count        <= '0;
         for (int j = 0; j < TWO_T; j++) syn[j] <= '0;
         IN_READY     <= 1'b1;
         OUT_VALID    <= 1'b0;
         OUT_SYNDROME <= '0;
         OUT_INDEX    <= '0;
         OUT_LAST     <= 1'b0;
         ERR_FREE     <= 1'b0;
      end else if (CLR) begin
         state        <= ACCUM;
         count        <= '0;
         for (int j = 0; j < TWO_T; j++) syn[j] <= '0;
         IN_READY     <= 1'b1;
         OUT_VALID    <= 1'b0;
         OUT_SYNDROME <= '0;
         OUT_INDEX    <= '0;
         OUT_LAST     <= 1'b0;
         ERR_FREE     <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (IN_VALID) begin
                  for (int j = 0; j < TWO_T; j++) syn[j] <= acc_next[j];
                  if (count == CNT_W'(N - 1)) begin
                     state        <= DRAIN;
                     count        <= '0;
                     IN_READY     <= 1'b0;
                     OUT_VALID    <= 1'b1;
                     OUT_SYNDROME <= acc_next[0];
                     OUT_INDEX    <= '0;
                     OUT_LAST     <= (TWO_T == 1);
                     ERR_FREE     <= ~acc_nonzero;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (OUT_READY) begin
                  if (OUT_LAST) begin
                     state        <= ACCUM;
                     IN_READY     <= 1'b1;
                     OUT_VALID    <= 1'b0;
                     OUT_SYNDROME <= '0;
                     OUT_INDEX    <= '0;
                     OUT_LAST     <= 1'b0;
                     ERR_FREE     <= 1'b0;
                  end else begin
                     OUT_SYNDROME <= syn[idx_inc];
                     OUT_INDEX    <= idx_inc;
                     OUT_LAST     <= (idx_inc == IDX_W'(TWO_T - 1));
                  end
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_syndrome_gen.sv
// Self-checking bench for rs_syndrome_gen with default parameters.
// The reference model evaluates each syndrome directly as a sum of
// r_i * alpha^((FCR+j)*i) using log/antilog tables.
module tb_rs_syndrome_gen;

   localparam int M = 4;
   localparam int N = 15;
   localparam int T = 4;
   localparam int FCR = 1;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       CLR;
   logic       IN_VALID;
   logic [3:0] IN_SYMBOL;
   logic       IN_READY;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic [3:0] OUT_SYNDROME;
   logic [1:0] OUT_INDEX;
   logic       OUT_LAST;
   logic       ERR_FREE;

   rs_syndrome_gen #(.M(M), .N(N), .TWO_T(T), .PRIM_POLY(19), .FCR(FCR)) dut (
      .CLK(CLK), .RESET(RESET), .CLR(CLR),
      .IN_VALID(IN_VALID), .IN_SYMBOL(IN_SYMBOL), .IN_READY(IN_READY),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SYNDROME(OUT_SYNDROME),
      .OUT_INDEX(OUT_INDEX), .OUT_LAST(OUT_LAST), .ERR_FREE(ERR_FREE)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   int ex [15];
   int lg [16];
   int frame [N];
   int exp_syn [T];
   int got_syn [T];
   bit exp_ef;
   int exp_idx;
   bit exp_armed = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
      end
   endtask

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return ex[(lg[a] + lg[b]) % 15];
   endfunction

   // Direct polynomial evaluation: the k-th sent symbol is the coefficient of x^(N-1-k).
   task automatic model_frame();
      int nz;
      nz = 0;
      for (int j = 0; j < T; j++) begin
         exp_syn[j] = 0;
         for (int k = 0; k < N; k++) begin
            int i;
            i = N - 1 - k;
            exp_syn[j] = exp_syn[j] ^ gmul(frame[k], ex[((FCR + j) * i) % 15]);
         end
         if (exp_syn[j] != 0) nz = 1;
      end
      exp_ef = (nz == 0);
   endtask

   task automatic set_single(input int k, input int v);
      for (int i = 0; i < N; i++) frame[i] = 0;
      frame[k] = v;
   endtask

   // Single compare process: every beat presented must match the model.
   always @(negedge CLK) begin
      if (!RESET) begin
         if (OUT_VALID) begin
            check("in_ready_low_in_drain", IN_READY, 0);
            if (!exp_armed) check("unexpected_out_valid", OUT_VALID, 0);
            else begin
               check("syndrome", OUT_SYNDROME, exp_syn[exp_idx]);
               check("index", OUT_INDEX, exp_idx);
               check("last", OUT_LAST, (exp_idx == T - 1));
               check("err_free", ERR_FREE, exp_ef);
               if (OUT_READY) begin
                  got_syn[exp_idx] = OUT_SYNDROME;
                  exp_idx++;
                  if (exp_idx == T) exp_armed = 1'b0;
               end
            end
         end else begin
            check("in_ready_high_in_accum", IN_READY, 1);
         end
      end
   end

   task automatic send_sym(input int s);
      int c;
      IN_VALID  = 1'b1;
      IN_SYMBOL = s[3:0];
      c = 0;
      do begin
         @(negedge CLK);
         c++;
      end while (!IN_READY && c < 100);
      if (c >= 100) check("accept_timeout", 0, 1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
   endtask

   task automatic send_count(input int cnt, input int v);
      for (int k = 0; k < cnt; k++) send_sym(v);
   endtask

   task automatic send_frame(input bit gapped);
      for (int k = 0; k < N; k++) begin
         send_sym(frame[k]);
         if (gapped && k < N - 1) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge CLK);
               #1;
            end
         end
      end
      model_frame();
      exp_idx   = 0;
      exp_armed = 1'b1;
      check("first_beat_latency", OUT_VALID, 1);
      check("in_ready_drop", IN_READY, 0);
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while (exp_armed && c < 60) begin
         @(posedge CLK);
         c++;
      end
      check("drain_timeout", exp_armed, 0);
      #1;
      check("in_ready_after_last", IN_READY, 1);
      check("out_valid_after_last", OUT_VALID, 0);
   endtask

   task automatic check_got(input string name, input int a, input int b, input int c, input int d);
      check({name, "_s0"}, got_syn[0], a);
      check({name, "_s1"}, got_syn[1], b);
      check({name, "_s2"}, got_syn[2], c);
      check({name, "_s3"}, got_syn[3], d);
   endtask

   task automatic check_idle(input string name);
      check({name, "_in_ready"}, IN_READY, 1);
      check({name, "_out_valid"}, OUT_VALID, 0);
      check({name, "_syndrome"}, OUT_SYNDROME, 0);
      check({name, "_index"}, OUT_INDEX, 0);
      check({name, "_last"}, OUT_LAST, 0);
      check({name, "_err_free"}, ERR_FREE, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ex[0] = 1;
      for (int i = 1; i < 15; i++) begin
         ex[i] = ex[i - 1] << 1;
         if (ex[i] & 16) ex[i] = ex[i] ^ 19;
      end
      lg[0] = 0;
      for (int i = 0; i < 15; i++) lg[ex[i]] = i;

      RESET = 1'b1; CLR = 1'b0; IN_VALID = 1'b0; IN_SYMBOL = '0; OUT_READY = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      check_idle("reset");

      // Pin the model against hand-computed syndromes.
      set_single(13, 1);
      model_frame();
      check("model_x1_s0", exp_syn[0], 2);
      check("model_x1_s3", exp_syn[3], 3);
      set_single(0, 1);
      model_frame();
      check("model_x14_s1", exp_syn[1], 13);
      check("model_x14_s2", exp_syn[2], 15);

      // All-zero frame.
      set_single(0, 0);
      send_frame(1'b0);
      check("zero_err_free", ERR_FREE, 1);
      wait_drain();
      check_got("zero", 0, 0, 0, 0);

      // Error at x^0.
      set_single(14, 1);
      send_frame(1'b0);
      check("x0_err_free", ERR_FREE, 0);
      wait_drain();
      check_got("x0", 1, 1, 1, 1);

      // Error at x^1.
      set_single(13, 1);
      send_frame(1'b0);
      wait_drain();
      check_got("x1", 2, 4, 8, 3);

      // Error at x^14, contiguous then gapped.
      set_single(0, 1);
      send_frame(1'b0);
      wait_drain();
      check_got("x14", 9, 13, 15, 14);
      send_frame(1'b1);
      wait_drain();
      check_got("x14_gapped", 9, 13, 15, 14);

      // Backpressure at idx 1 while offering input that must not be taken.
      set_single(13, 1);
      send_frame(1'b0);
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      IN_SYMBOL = 4'd7;
      repeat (3) begin
         @(posedge CLK);
         #1;
         check("bp_hold_syndrome", OUT_SYNDROME, 4);
         check("bp_hold_index", OUT_INDEX, 1);
         check("bp_in_ready", IN_READY, 0);
      end
      OUT_READY = 1'b1;
      IN_VALID  = 1'b0;
      wait_drain();
      check_got("bp", 2, 4, 8, 3);

      // RESET pulse mid-frame.
      send_count(7, 5);
      RESET = 1'b1;
      #2;
      RESET = 1'b0;
      check_idle("reset_mid");
      set_single(14, 1);
      send_frame(1'b0);
      wait_drain();
      check_got("after_reset", 1, 1, 1, 1);

      // CLR mid-frame.
      send_count(7, 6);
      CLR = 1'b1;
      @(posedge CLK);
      #1;
      CLR = 1'b0;
      check_idle("clr_mid");
      send_frame(1'b0);
      wait_drain();
      check_got("after_clr", 1, 1, 1, 1);

      // CLR during drain at idx 2.
      set_single(13, 1);
      send_frame(1'b0);
      repeat (2) begin
         @(posedge CLK);
         #1;
      end
      check("clr_drain_at_idx2", OUT_INDEX, 2);
      CLR = 1'b1;
      @(posedge CLK);
      #1;
      CLR = 1'b0;
      exp_armed = 1'b0;
      check_idle("clr_drain");
      set_single(14, 1);
      send_frame(1'b0);
      wait_drain();
      check_got("after_clr_drain", 1, 1, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rs_syndrome_gen.md
Name: rs_syndrome_gen

Overview:
Parametrised Reed-Solomon syndrome generator over GF(2^M). It is the successor to the fixed 15/11 syndrome stage.
- Accepts one received symbol per cycle (highest-degree coefficient first) using a valid/ready handshake.
- Accumulates all TWO_T syndromes in parallel with Horner evaluation.
- Streams the syndromes serially to the key-equation stage, together with an error-free flag.
- Sits between the input symbol stream and the Berlekamp-Massey/Euclid block.

Parameters:
- M, 4: symbol width in bits; field is GF(2^M).
- N, 15: codeword length in symbols; range 2..2^M-1.
- TWO_T, 4: number of syndromes (parity symbols); range 1..N-1.
- PRIM_POLY, 19: primitive polynomial as an (M+1)-bit value. 19 = x^4+x+1.
- FCR, 1: first consecutive root exponent. Syndrome j evaluates at alpha^(FCR+j), where alpha = 2.

Ports:
- CLK, input, 1: clock; all state changes on the rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- CLR, input, 1: synchronous abort; same effect as RESET, applied at the next edge.
- IN_VALID, input, 1: IN_SYMBOL is valid.
- IN_SYMBOL, input, M: received symbol r_(N-1-k) for the k-th accepted symbol.
- IN_READY, output, 1: block accepts a symbol this cycle.
- OUT_VALID, output, 1: OUT_SYNDROME is valid.
- OUT_READY, input, 1: downstream accepts the syndrome.
- OUT_SYNDROME, output, M: syndrome S_idx.
- OUT_INDEX, output, clog2(TWO_T) (min 1): index of the presented syndrome.
- OUT_LAST, output, 1: high with the S_(TWO_T-1) beat.
- ERR_FREE, output, 1: all TWO_T syndromes are zero; valid whenever OUT_VALID is high.

Behaviour:
- Reset (RESET asserted, or CLR at an edge):
  - state goes to ACCUM; symbol counter, output index and all accumulators go to 0.
  - IN_READY=1; OUT_VALID=0, OUT_SYNDROME=0, OUT_INDEX=0, OUT_LAST=0, ERR_FREE=0.
  - RESET mid-frame or mid-drain discards everything; the next accepted symbol is treated as r_(N-1).
- States: ACCUM, DRAIN.
- ACCUM:
  - IN_READY=1, OUT_VALID=0.
  - A symbol is accepted when IN_VALID=1 and IN_READY=1.
  - On the first accept (count=0): S_j <= IN_SYMBOL. This loads the accumulators, so no separate clear cycle is needed.
  - Otherwise: S_j <= gfmul(S_j, alpha^(FCR+j)) XOR IN_SYMBOL, for every j.
  - The count increments on each accept.
  - On the accept with count=N-1: go to DRAIN, count<=0, idx<=0.
- GF arithmetic:
  - Multiply-by-constant is combinational XOR logic, reduced modulo PRIM_POLY.
  - The constants alpha^(FCR+j) are computed at elaboration time by a function; no lookup RAM.
  - Addition is XOR. All widths are exactly M bits.
- DRAIN:
  - IN_READY=0; IN_VALID is ignored and never consumed.
  - OUT_VALID=1, OUT_SYNDROME=S_idx, OUT_INDEX=idx, OUT_LAST=(idx==TWO_T-1).
  - ERR_FREE is the registered NOR of all accumulators, computed on entry to DRAIN and stable for the whole drain.
  - A beat transfers when OUT_VALID=1 and OUT_READY=1; then idx increments.
  - While OUT_READY=0, all outputs hold stable.
  - The transfer of the OUT_LAST beat returns the block to ACCUM, with IN_READY=1 on the next cycle.
- Latency:
  - The first syndrome appears one cycle after the Nth symbol is accepted.
  - Drain takes TWO_T cycles with no backpressure.
  - Frame throughput is N+TWO_T cycles; input and output do not overlap.
- Accepting no symbols leaves the state unchanged (IN_VALID gaps are allowed anywhere in a frame).
- Outputs are registered: OUT_* is driven from registers, not from combinational paths fed by inputs.
- Elaboration fails if the PRIM_POLY bit M is not set, or if TWO_T >= N.

Test Plan:
All tests use the defaults (M=4, N=15, TWO_T=4, PRIM_POLY=19, FCR=1) and OUT_READY=1 unless stated.
- All-zero frame, 15 symbols of 0, IN_VALID=1 throughout -> beats S0..S3 = 0,0,0,0; ERR_FREE=1; OUT_LAST on idx 3; IN_READY=1 again one cycle after the last beat.
- Frame of 14 zeros then 1 (error at x^0) -> syndromes 1,1,1,1; ERR_FREE=0.
- Frame of 13 zeros, then 1, then 0 (error at x^1) -> syndromes 2,4,8,3.
- Frame of 1 then 14 zeros (error at x^14) -> syndromes 9,13,15,14; IN_VALID randomly gapped gives the same result.
- Backpressure, error-at-x^1 frame with OUT_READY low for 3 cycles at idx 1 -> OUT_SYNDROME stays 4, OUT_INDEX stays 1; IN_READY=0 and IN_VALID symbols are not consumed; full sequence 2,4,8,3 delivered.
- Assert RESET for 2 ns after 7 symbols, then send a full all-zero-except-x^0=1 frame -> syndromes 1,1,1,1. Repeat with CLR instead of RESET, and again with CLR during DRAIN at idx 2 -> drain aborts (OUT_VALID=0) and the next frame is correct.
